// File: rtl/icache_refill_pkg.sv
// icache_refill_pkg: shared types, default geometry and address helpers for the I-cache refill path.
`default_nettype none

package icache_refill_pkg;

  localparam int DEF_SIZE_PC     = 32;
  localparam int DEF_CACHE_WIDTH = 256;
  localparam int DEF_MEM_WIDTH   = 64;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    RECV  = 3'd2,
    WRITE = 3'd3,
    DONE  = 3'd4
  } state_t;

  // Number of memory beats per cache block.
  function automatic int beats_of(input int cache_width, input int mem_width);
    return cache_width / mem_width;
  endfunction

  // Byte-offset bits inside one cache line.
  function automatic int offs_of(input int cache_width);
    return $clog2(cache_width / 8);
  endfunction

  // Beat-counter width; never narrower than one bit.
  function automatic int cnt_w_of(input int beats);
    return (beats > 1) ? $clog2(beats) : 1;
  endfunction

  function automatic logic [63:0] line_align(input logic [63:0] addr, input int unsigned offs);
    return addr & ~((64'd1 << offs) - 64'd1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/icache_refill_ctrl_line_buffer.sv
// refill_line_buffer: collects memory beats into one cache block at a beat-indexed slot.
`default_nettype none

module refill_line_buffer #(
  parameter int CACHE_WIDTH = 256,
  parameter int MEM_WIDTH   = 64,
  parameter int CNT_W       = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wr_en,
  input  logic [CNT_W-1:0]       beat_idx,
  input  logic [MEM_WIDTH-1:0]   beat_data,
  output logic [CACHE_WIDTH-1:0] block
);

  localparam int NBEATS = CACHE_WIDTH / MEM_WIDTH;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      block <= '0;
    end else begin
      for (int b = 0; b < NBEATS; b++) begin
        if (wr_en && (beat_idx == CNT_W'(b))) begin
          block[b*MEM_WIDTH +: MEM_WIDTH] <= beat_data;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/icache_refill_ctrl.sv
// icache_refill_ctrl: fetches a missed I-cache line from lower memory and writes it
// back through the cache fill port in a single cycle.
`default_nettype none

module icache_refill_ctrl
  import icache_refill_pkg::*;
#(
  parameter int SIZE_PC     = DEF_SIZE_PC,
  parameter int CACHE_WIDTH = DEF_CACHE_WIDTH,
  parameter int MEM_WIDTH   = DEF_MEM_WIDTH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   miss_i,
  input  logic [SIZE_PC-1:0]     missAddr_i,
  output logic                   memReq_o,
  output logic [SIZE_PC-1:0]     memAddr_o,
  input  logic                   memReqAck_i,
  input  logic                   memDataValid_i,
  input  logic [MEM_WIDTH-1:0]   memData_i,
  output logic                   wrEnable_o,
  output logic [SIZE_PC-1:0]     wrAddr_o,
  output logic [CACHE_WIDTH-1:0] instBlock_o,
  output logic                   busy_o,
  output logic [15:0]            fillCount_o
);

  localparam int NBEATS    = beats_of(CACHE_WIDTH, MEM_WIDTH);
  localparam int LINE_OFFS = offs_of(CACHE_WIDTH);
  localparam int CNT_W     = cnt_w_of(NBEATS);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NBEATS - 1);

  state_t             state;
  state_t             state_nxt;
  logic [CNT_W-1:0]   beat_cnt;
  logic [15:0]        fill_count;
  logic [SIZE_PC-1:0] miss_line;
  logic               beat_wr;
  logic               last_beat;

  assign miss_line   = SIZE_PC'(line_align(64'(missAddr_i), LINE_OFFS));
  assign beat_wr     = (state == RECV) && memDataValid_i;
  assign last_beat   = beat_wr && (beat_cnt == LAST_BEAT);
  assign fillCount_o = fill_count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (miss_i)      state_nxt = REQ;
      REQ:     if (memReqAck_i) state_nxt = RECV;
      RECV:    if (last_beat)   state_nxt = WRITE;
      WRITE:   state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Strobes are registered from the next state so they line up with the state itself.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      memReq_o   <= 1'b0;
      wrEnable_o <= 1'b0;
      busy_o     <= 1'b0;
      memAddr_o  <= '0;
      wrAddr_o   <= '0;
      beat_cnt   <= '0;
    end else begin
      memReq_o   <= (state_nxt == REQ);
      wrEnable_o <= (state_nxt == WRITE);
      busy_o     <= (state_nxt != IDLE);
      if ((state == IDLE) && miss_i) begin
        memAddr_o <= miss_line;
      end
      if (state_nxt == WRITE) begin
        wrAddr_o <= memAddr_o;
      end
      if (state == REQ) begin
        beat_cnt <= '0;
      end else if (beat_wr) begin
        beat_cnt <= beat_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fill_count <= '0;
    end else if ((state_nxt == WRITE) && (fill_count != 16'hFFFF)) begin
      fill_count <= fill_count + 16'd1;
    end
  end

  refill_line_buffer #(
    .CACHE_WIDTH (CACHE_WIDTH),
    .MEM_WIDTH   (MEM_WIDTH),
    .CNT_W       (CNT_W)
  ) u_line_buffer (
    .clk       (clk),
    .reset     (reset),
    .wr_en     (beat_wr),
    .beat_idx  (beat_cnt),
    .beat_data (memData_i),
    .block     (instBlock_o)
  );

endmodule

`default_nettype wire

// File: tb/tb_icache_refill_ctrl.sv
// tb_icache_refill_ctrl: directed, table-driven checks of the I-cache refill controller.
`default_nettype none

module tb_icache_refill_ctrl;

  logic         clk = 1'b0;
  logic         reset;
  logic         miss;
  logic [31:0]  missAddr;
  logic         memReq;
  logic [31:0]  memAddr;
  logic         ack;
  logic         dv;
  logic [63:0]  data;
  logic         wrEnable;
  logic [31:0]  wrAddr;
  logic [255:0] instBlock;
  logic         busy;
  logic [15:0]  fillCount;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  icache_refill_ctrl dut (
    .clk            (clk),
    .reset          (reset),
    .miss_i         (miss),
    .missAddr_i     (missAddr),
    .memReq_o       (memReq),
    .memAddr_o      (memAddr),
    .memReqAck_i    (ack),
    .memDataValid_i (dv),
    .memData_i      (data),
    .wrEnable_o     (wrEnable),
    .wrAddr_o       (wrAddr),
    .instBlock_o    (instBlock),
    .busy_o         (busy),
    .fillCount_o    (fillCount)
  );

  typedef struct {
    logic        miss;
    logic [31:0] addr;
    logic        ack;
    logic        dv;
    logic [63:0] data;
    logic        e_req;
    logic        e_busy;
    logic        e_wr;
    logic [31:0] e_maddr;
    logic [31:0] e_waddr;
    logic [15:0] e_fill;
  } vec_t;

  vec_t vecs [9];

  logic [255:0] B1, B2, B3, B4, B5;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drives four back-to-back beats; returns at the negedge of the WRITE cycle.
  task automatic send_beats(input logic [255:0] blk);
    for (int k = 0; k < 4; k++) begin
      dv   = 1'b1;
      data = blk[k*64 +: 64];
      @(negedge clk);
    end
    dv   = 1'b0;
    data = '0;
  endtask

  // Minimum-latency refill starting from IDLE; returns in the following IDLE cycle.
  task automatic fill(input logic [31:0] addr, input logic [255:0] blk, input string tag);
    miss     = 1'b1;
    missAddr = addr;
    @(negedge clk);
    miss = 1'b0;
    ack  = 1'b1;
    chk({tag, "_req"}, 256'(memReq), 256'(1'b1));
    chk({tag, "_maddr"}, 256'(memAddr), 256'(addr & 32'hFFFF_FFE0));
    @(negedge clk);
    ack = 1'b0;
    send_beats(blk);
    chk({tag, "_wr"}, 256'(wrEnable), 256'(1'b1));
    chk({tag, "_waddr"}, 256'(wrAddr), 256'(addr & 32'hFFFF_FFE0));
    chk({tag, "_block"}, instBlock, blk);
    @(negedge clk);
    chk({tag, "_wr_off"}, 256'(wrEnable), 256'(1'b0));
    @(negedge clk);
    chk({tag, "_idle"}, 256'(busy), 256'(1'b0));
  endtask

  initial begin
    #400000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    B1 = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
          64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
    B2 = {64'hA3A3_0000_0000_0003, 64'hA2A2_0000_0000_0002,
          64'hA1A1_0000_0000_0001, 64'hA0A0_0000_0000_0000};
    B3 = {64'hC0DE_0003_0000_0000, 64'hC0DE_0002_0000_0000,
          64'hC0DE_0001_0000_0000, 64'hC0DE_0000_0000_0000};
    B4 = {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
          64'h5555_AAAA_5555_AAAA, 64'h0F0F_F0F0_0F0F_F0F0};
    B5 = {64'h0D0D_0D0D_0D0D_0D0D, 64'h0C0C_0C0C_0C0C_0C0C,
          64'h0B0B_0B0B_0B0B_0B0B, 64'h0A0A_0A0A_0A0A_0A0A};

    // Rows are cycles: inputs driven in that cycle, outputs expected during it.
    // Stray beats in rows 0 (IDLE) and 1 (REQ) must be dropped.
    vecs[0] = '{1'b1, 32'h0000_1234, 1'b0, 1'b1, 64'hDEAD_DEAD_DEAD_DEAD, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 16'd0};
    vecs[1] = '{1'b0, 32'h0000_1234, 1'b1, 1'b1, 64'hBEEF_BEEF_BEEF_BEEF, 1'b1, 1'b1, 1'b0, 32'h0000_1220, 32'h0, 16'd0};
    vecs[2] = '{1'b0, 32'h0000_1234, 1'b0, 1'b1, 64'h1111_1111_1111_1111, 1'b0, 1'b1, 1'b0, 32'h0000_1220, 32'h0, 16'd0};
    vecs[3] = '{1'b0, 32'h0000_1234, 1'b0, 1'b1, 64'h2222_2222_2222_2222, 1'b0, 1'b1, 1'b0, 32'h0000_1220, 32'h0, 16'd0};
    vecs[4] = '{1'b0, 32'h0000_1234, 1'b0, 1'b1, 64'h3333_3333_3333_3333, 1'b0, 1'b1, 1'b0, 32'h0000_1220, 32'h0, 16'd0};
    vecs[5] = '{1'b0, 32'h0000_1234, 1'b0, 1'b1, 64'h4444_4444_4444_4444, 1'b0, 1'b1, 1'b0, 32'h0000_1220, 32'h0, 16'd0};
    vecs[6] = '{1'b0, 32'h0000_1234, 1'b0, 1'b0, 64'h0, 1'b0, 1'b1, 1'b1, 32'h0000_1220, 32'h0000_1220, 16'd1};
    vecs[7] = '{1'b0, 32'h0000_1234, 1'b0, 1'b0, 64'h0, 1'b0, 1'b1, 1'b0, 32'h0000_1220, 32'h0000_1220, 16'd1};
    vecs[8] = '{1'b0, 32'h0000_1234, 1'b0, 1'b0, 64'h0, 1'b0, 1'b0, 1'b0, 32'h0000_1220, 32'h0000_1220, 16'd1};

    reset = 1'b0; miss = 1'b0; missAddr = '0; ack = 1'b0; dv = 1'b0; data = '0;
    repeat (3) @(negedge clk);
    chk("rst_req",   256'(memReq),    256'(0));
    chk("rst_wr",    256'(wrEnable),  256'(0));
    chk("rst_busy",  256'(busy),      256'(0));
    chk("rst_maddr", 256'(memAddr),   256'(0));
    chk("rst_waddr", 256'(wrAddr),    256'(0));
    chk("rst_block", instBlock,       256'(0));
    chk("rst_fill",  256'(fillCount), 256'(0));
    reset = 1'b1;

    // Basic minimum-latency refill.
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      miss = vecs[i].miss; missAddr = vecs[i].addr; ack = vecs[i].ack;
      dv = vecs[i].dv; data = vecs[i].data;
      chk($sformatf("vec%0d_req", i),   256'(memReq),    256'(vecs[i].e_req));
      chk($sformatf("vec%0d_busy", i),  256'(busy),      256'(vecs[i].e_busy));
      chk($sformatf("vec%0d_wr", i),    256'(wrEnable),  256'(vecs[i].e_wr));
      chk($sformatf("vec%0d_maddr", i), 256'(memAddr),   256'(vecs[i].e_maddr));
      chk($sformatf("vec%0d_waddr", i), 256'(wrAddr),    256'(vecs[i].e_waddr));
      chk($sformatf("vec%0d_fill", i),  256'(fillCount), 256'(vecs[i].e_fill));
    end
    chk("vec_block", instBlock, B1);

    // Ack delayed three cycles, bubble between beats 1 and 2.
    @(negedge clk);
    miss = 1'b1; missAddr = 32'h0000_3044; ack = 1'b0; dv = 1'b0;
    @(negedge clk);
    miss = 1'b0;
    for (int w = 0; w < 4; w++) begin
      chk("dly_req_held", 256'(memReq), 256'(1));
      chk("dly_maddr_stable", 256'(memAddr), 256'(32'h0000_3040));
      ack = (w == 3);
      @(negedge clk);
    end
    ack = 1'b0;
    chk("dly_req_drop", 256'(memReq), 256'(0));
    dv = 1'b1; data = B2[63:0];
    @(negedge clk);
    data = B2[127:64];
    @(negedge clk);
    dv = 1'b0;
    @(negedge clk);
    dv = 1'b1; data = B2[191:128];
    @(negedge clk);
    chk("dly_no_early_wr", 256'(wrEnable), 256'(0));
    data = B2[255:192];
    @(negedge clk);
    dv = 1'b0;
    chk("dly_wr", 256'(wrEnable), 256'(1));
    chk("dly_waddr", 256'(wrAddr), 256'(32'h0000_3040));
    chk("dly_block", instBlock, B2);
    chk("dly_fill", 256'(fillCount), 256'(2));
    @(negedge clk);
    chk("dly_wr_off", 256'(wrEnable), 256'(0));
    @(negedge clk);
    chk("dly_idle", 256'(busy), 256'(0));

    // Miss held high throughout, address redirected during RECV.
    miss = 1'b1; missAddr = 32'h0000_1234;
    @(negedge clk);
    ack = 1'b1;
    chk("redir_req", 256'(memReq), 256'(1));
    @(negedge clk);
    ack = 1'b0; missAddr = 32'h0000_2000;
    for (int k = 0; k < 4; k++) begin
      chk("redir_no_req", 256'(memReq), 256'(0));
      dv = 1'b1; data = B3[k*64 +: 64];
      @(negedge clk);
    end
    dv = 1'b0;
    chk("redir_wr", 256'(wrEnable), 256'(1));
    chk("redir_waddr", 256'(wrAddr), 256'(32'h0000_1220));
    chk("redir_block", instBlock, B3);
    @(negedge clk);
    chk("redir_done_wr", 256'(wrEnable), 256'(0));
    chk("redir_done_req", 256'(memReq), 256'(0));
    @(negedge clk);
    chk("redir_idle_busy", 256'(busy), 256'(0));
    chk("redir_idle_wr", 256'(wrEnable), 256'(0));
    chk("redir_idle_req", 256'(memReq), 256'(0));
    @(negedge clk);
    chk("redir_new_req", 256'(memReq), 256'(1));
    chk("redir_new_maddr", 256'(memAddr), 256'(32'h0000_2000));
    miss = 1'b0; ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    send_beats(B4);
    chk("redir2_wr", 256'(wrEnable), 256'(1));
    chk("redir2_waddr", 256'(wrAddr), 256'(32'h0000_2000));
    chk("redir2_block", instBlock, B4);
    chk("redir2_fill", 256'(fillCount), 256'(4));
    repeat (2) @(negedge clk);
    chk("redir2_idle", 256'(busy), 256'(0));

    // Reset asserted after two beats of a refill.
    miss = 1'b1; missAddr = 32'h0000_4ABC;
    @(negedge clk);
    miss = 1'b0; ack = 1'b1;
    @(negedge clk);
    ack = 1'b0; dv = 1'b1; data = 64'hAAAA_AAAA_AAAA_AAAA;
    @(negedge clk);
    data = 64'hBBBB_BBBB_BBBB_BBBB;
    @(negedge clk);
    dv = 1'b0;
    reset = 1'b0;
    #1;
    chk("abort_busy",  256'(busy),      256'(0));
    chk("abort_req",   256'(memReq),    256'(0));
    chk("abort_wr",    256'(wrEnable),  256'(0));
    chk("abort_maddr", 256'(memAddr),   256'(0));
    chk("abort_waddr", 256'(wrAddr),    256'(0));
    chk("abort_block", instBlock,       256'(0));
    chk("abort_fill",  256'(fillCount), 256'(0));
    repeat (2) begin
      @(negedge clk);
      chk("abort_no_wr", 256'(wrEnable), 256'(0));
    end
    @(negedge clk);
    reset = 1'b1;
    fill(32'h0000_4ABC, B5, "after_rst");
    chk("after_rst_fill", 256'(fillCount), 256'(1));

    // Stray beat while idle.
    dv = 1'b1; data = 64'hFFFF_FFFF_FFFF_FFFF;
    @(negedge clk);
    dv = 1'b0; data = '0;
    chk("stray_busy",  256'(busy),      256'(0));
    chk("stray_req",   256'(memReq),    256'(0));
    chk("stray_block", instBlock,       B5);
    chk("stray_fill",  256'(fillCount), 256'(1));

    // Fill counter saturation, preloaded near the top of its range.
    force dut.fill_count = 16'hFFFD;
    @(negedge clk);
    release dut.fill_count;
    chk("sat_preload", 256'(fillCount), 256'(16'hFFFD));
    fill(32'h0000_6000, B1, "sat1");
    chk("sat1_fill", 256'(fillCount), 256'(16'hFFFE));
    fill(32'h0000_6020, B2, "sat2");
    chk("sat2_fill", 256'(fillCount), 256'(16'hFFFF));
    fill(32'h0000_6047, B3, "sat3");
    chk("sat3_fill", 256'(fillCount), 256'(16'hFFFF));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
